// File: rtl/hdmi_timing_pkg.sv
// Shared definitions for the HDMI output timing path: 720p defaults,
// colour-bar palette and controller state encoding.
package hdmi_timing_pkg;

  localparam int H_ACTIVE_720P = 1280;
  localparam int H_FP_720P     = 110;
  localparam int H_SYNC_720P   = 40;
  localparam int H_BP_720P     = 220;
  localparam int V_ACTIVE_720P = 720;
  localparam int V_FP_720P     = 5;
  localparam int V_SYNC_720P   = 5;
  localparam int V_BP_720P     = 20;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/hdmi_timing_ctrl_if.sv
// Pixel FIFO read port between the timing controller (master) and the
// DDR3 frame-buffer read FIFO (slave). Read data is valid one cycle after the pop.
interface hdmi_timing_ctrl_if;
  logic        fifo_empty;
  logic [23:0] fifo_rdata;
  logic        fifo_rd_en;

  modport master (input fifo_empty, input fifo_rdata, output fifo_rd_en);
  modport slave  (output fifo_empty, output fifo_rdata, input fifo_rd_en);
endinterface

// File: rtl/video_timing_cnt.sv
// Raster h/v counters with active/sync decodes, frame-end strobe and the
// per-frame fetch point (h=0, v=V_ACTIVE) used to kick the DDR3 reader.
module video_timing_cnt
  import hdmi_timing_pkg::*;
#(
  parameter  int H_ACTIVE = H_ACTIVE_720P,
  parameter  int H_FP     = H_FP_720P,
  parameter  int H_SYNC   = H_SYNC_720P,
  parameter  int H_BP     = H_BP_720P,
  parameter  int V_ACTIVE = V_ACTIVE_720P,
  parameter  int V_FP     = V_FP_720P,
  parameter  int V_SYNC   = V_SYNC_720P,
  parameter  int V_BP     = V_BP_720P,
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW       = $clog2(H_TOTAL),
  localparam int VW       = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          adv_i,
  output logic [HW-1:0] h_cnt_o,
  output logic          active_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          frame_end_o,
  output logic          fetch_o
);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [HW-1:0] h_q;
  logic [VW-1:0] v_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else if (load_i) begin
      h_q <= '0;
      v_q <= V_ACT;
    end else if (adv_i) begin
      if (h_q == H_LAST) begin
        h_q <= '0;
        v_q <= (v_q == V_LAST) ? '0 : v_q + VW'(1);
      end else begin
        h_q <= h_q + HW'(1);
      end
    end
  end

  assign h_cnt_o     = h_q;
  assign active_o    = (h_q < H_ACT) && (v_q < V_ACT);
  assign hsync_o     = (h_q >= HS_BEG) && (h_q <= HS_END);
  assign vsync_o     = (v_q >= VS_BEG) && (v_q <= VS_END);
  assign frame_end_o = (h_q == H_LAST) && (v_q == V_LAST);
  assign fetch_o     = (h_q == '0) && (v_q == V_ACT);

endmodule

// File: rtl/hdmi_timing_ctrl.sv
// Video timing controller: run/idle FSM, FIFO/colour-bar pixel mux,
// underflow accounting and a 2-stage registered video output pipeline.
module hdmi_timing_ctrl
  import hdmi_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_720P,
  parameter int H_FP     = H_FP_720P,
  parameter int H_SYNC   = H_SYNC_720P,
  parameter int H_BP     = H_BP_720P,
  parameter int V_ACTIVE = V_ACTIVE_720P,
  parameter int V_FP     = V_FP_720P,
  parameter int V_SYNC   = V_SYNC_720P,
  parameter int V_BP     = V_BP_720P,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic                      clk_1x,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      pat_sel,
  hdmi_timing_ctrl_if.master        fifo_if,
  output logic                      frame_start,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      rgb_valid,
  output logic [23:0]               rgb_data,
  output logic                      underflow,
  output logic [15:0]               underflow_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int BAR_W   = H_ACTIVE / 8;

  state_e        state_q;
  logic          pat_q;
  logic [HW-1:0] h_cnt;
  logic          active, hs_reg, vs_reg, frame_end, fetch;
  logic          run, load;

  assign run  = (state_q == ST_RUN);
  assign load = (state_q == ST_IDLE) && enable;

  video_timing_cnt #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_cnt (
    .clk        (clk_1x),
    .rst_n      (rst_n),
    .load_i     (load),
    .adv_i      (run),
    .h_cnt_o    (h_cnt),
    .active_o   (active),
    .hsync_o    (hs_reg),
    .vsync_o    (vs_reg),
    .frame_end_o(frame_end),
    .fetch_o    (fetch)
  );

  // Stopping and pattern changes only take effect on frame boundaries.
  always_ff @(posedge clk_1x) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pat_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (enable) begin
          state_q <= ST_RUN;
          pat_q   <= pat_sel;
        end
        ST_RUN: if (frame_end) begin
          pat_q <= pat_sel;
          if (!enable) state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Stage 0: decisions straight off the counters.
  logic       act0, uf0;
  logic [2:0] bar0;
  assign act0               = run && active;
  assign fifo_if.fifo_rd_en = act0 && !pat_q && !fifo_if.fifo_empty;
  assign uf0                = act0 && !pat_q && fifo_if.fifo_empty;
  assign bar0               = 3'(h_cnt / BAR_W);

  logic       de1_q, hs1_q, vs1_q, pat1_q, uf1_q;
  logic [2:0] bar1_q;
  logic [23:0] pix_d;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    pix_d = '0;
    if (de1_q) begin
      if (pat1_q)      pix_d = bar_color(bar1_q);
      else if (!uf1_q) pix_d = fifo_if.fifo_rdata;
    end
  end

  logic        hsync_q, vsync_q, rgb_valid_q, frame_start_q, underflow_q;
  logic [23:0] rgb_data_q;
  logic [15:0] underflow_cnt_q;

  // fifo_rdata arrives during stage 1, so the stage-2 register captures it.
  always_ff @(posedge clk_1x) begin
    if (!rst_n) begin
      de1_q           <= 1'b0;
      hs1_q           <= 1'b0;
      vs1_q           <= 1'b0;
      pat1_q          <= 1'b0;
      uf1_q           <= 1'b0;
      bar1_q          <= '0;
      hsync_q         <= ~SYNC_POL;
      vsync_q         <= ~SYNC_POL;
      rgb_valid_q     <= 1'b0;
      rgb_data_q      <= '0;
      frame_start_q   <= 1'b0;
      underflow_q     <= 1'b0;
      underflow_cnt_q <= '0;
    end else begin
      de1_q         <= act0;
      hs1_q         <= run && hs_reg;
      vs1_q         <= run && vs_reg;
      pat1_q        <= pat_q;
      uf1_q         <= uf0;
      bar1_q        <= bar0;
      hsync_q       <= SYNC_POL ? hs1_q : ~hs1_q;
      vsync_q       <= SYNC_POL ? vs1_q : ~vs1_q;
      rgb_valid_q   <= de1_q;
      rgb_data_q    <= pix_d;
      frame_start_q <= run && fetch;
      if (uf0) begin
        underflow_q <= 1'b1;
        if (underflow_cnt_q != 16'hFFFF) underflow_cnt_q <= underflow_cnt_q + 16'd1;
      end
    end
  end

  assign hsync         = hsync_q;
  assign vsync         = vsync_q;
  assign rgb_valid     = rgb_valid_q;
  assign rgb_data      = rgb_data_q;
  assign frame_start   = frame_start_q;
  assign underflow     = underflow_q;
  assign underflow_cnt = underflow_cnt_q;

endmodule

// File: tb/tb_hdmi_timing_ctrl.sv
// Directed bench: two controllers with reduced timing (H 8/2/2/2 FIFO mode,
// H 16/2/2/2 colour bars, active-low sync), expected values computed by hand.
module tb_hdmi_timing_ctrl;

  logic clk_1x = 1'b0;
  always #5 clk_1x = ~clk_1x;

  logic        rst_n_a, enable_a, pat_sel_a;
  logic        fs_a, hs_a, vs_a, de_a, uf_a;
  logic [23:0] rgb_a;
  logic [15:0] ufc_a;
  logic        rst_n_b, enable_b, pat_sel_b;
  logic        fs_b, hs_b, vs_b, de_b, uf_b;
  logic [23:0] rgb_b;
  logic [15:0] ufc_b;

  hdmi_timing_ctrl_if fif_a ();
  hdmi_timing_ctrl_if fif_b ();

  hdmi_timing_ctrl #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
  ) dut_a (
    .clk_1x(clk_1x), .rst_n(rst_n_a), .enable(enable_a), .pat_sel(pat_sel_a),
    .fifo_if(fif_a), .frame_start(fs_a), .hsync(hs_a), .vsync(vs_a),
    .rgb_valid(de_a), .rgb_data(rgb_a), .underflow(uf_a), .underflow_cnt(ufc_a)
  );

  hdmi_timing_ctrl #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
  ) dut_b (
    .clk_1x(clk_1x), .rst_n(rst_n_b), .enable(enable_b), .pat_sel(pat_sel_b),
    .fifo_if(fif_b), .frame_start(fs_b), .hsync(hs_b), .vsync(vs_b),
    .rgb_valid(de_b), .rgb_data(rgb_b), .underflow(uf_b), .underflow_cnt(ufc_b)
  );

  int n_chk, n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Per-cycle statistics for DUT A. cyc is the index of the window being observed.
  int cyc, data_ctr, idle_from, idle_act;
  int rd_cnt, rd_first, de_cnt, de_first, fs_cnt, fs_first, fs_last;
  int hs_rise, vs_rise, hs_run, vs_run, hs_wmin, hs_wmax, vs_wmin, vs_wmax;
  logic hs_prev, vs_prev;
  logic [23:0] de_q[$];
  logic s_fs, s_hs, s_vs, s_de, s_uf, s_rd;
  logic [23:0] s_rgb;
  logic [15:0] s_ufc;

  task automatic clr_stats();
    rd_cnt = 0; rd_first = -1; de_cnt = 0; de_first = -1;
    fs_cnt = 0; fs_first = -1; fs_last = -1; hs_rise = 0; vs_rise = 0;
    hs_wmin = 1000; hs_wmax = 0; vs_wmin = 1000; vs_wmax = 0;
    de_q.delete();
  endtask

  task automatic cycle();
    logic rd_s;
    @(negedge clk_1x);
    rd_s = fif_a.fifo_rd_en;
    s_fs = fs_a; s_hs = hs_a; s_vs = vs_a; s_de = de_a; s_rgb = rgb_a;
    s_uf = uf_a; s_ufc = ufc_a; s_rd = rd_s;
    if (rd_s) begin rd_cnt++; if (rd_first < 0) rd_first = cyc; end
    if (de_a) begin de_cnt++; de_q.push_back(rgb_a); if (de_first < 0) de_first = cyc; end
    if (fs_a) begin fs_cnt++; fs_last = cyc; if (fs_first < 0) fs_first = cyc; end
    if (hs_a && !hs_prev) hs_rise++;
    if (vs_a && !vs_prev) vs_rise++;
    if (hs_a) hs_run++;
    else if (hs_run > 0) begin
      if (hs_run < hs_wmin) hs_wmin = hs_run;
      if (hs_run > hs_wmax) hs_wmax = hs_run;
      hs_run = 0;
    end
    if (vs_a) vs_run++;
    else if (vs_run > 0) begin
      if (vs_run < vs_wmin) vs_wmin = vs_run;
      if (vs_run > vs_wmax) vs_wmax = vs_run;
      vs_run = 0;
    end
    hs_prev = hs_a; vs_prev = vs_a;
    if (idle_from >= 0 && cyc >= idle_from &&
        (de_a || hs_a || vs_a || fs_a || rd_s || rgb_a != 24'h0)) idle_act++;
    @(posedge clk_1x);
    #1;
    if (rd_s) begin data_ctr++; fif_a.fifo_rdata = 24'(data_ctr); end
    cyc++;
  endtask

  task automatic run_until(input int k);
    while (cyc <= k) cycle();
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "/frame_start"}, s_fs, 0);
    check({tag, "/hsync"}, s_hs, 0);
    check({tag, "/vsync"}, s_vs, 0);
    check({tag, "/rgb_valid"}, s_de, 0);
    check({tag, "/rgb_data"}, s_rgb, 0);
    check({tag, "/fifo_rd_en"}, s_rd, 0);
    check({tag, "/underflow"}, s_uf, 0);
    check({tag, "/underflow_cnt"}, s_ufc, 0);
  endtask

  logic [23:0] bars [8];
  logic [23:0] bq[$];
  int b_rd, b_run, b_wmin, b_wmax;

  initial begin
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    n_chk = 0; n_pass = 0; cyc = 0; data_ctr = 0; idle_from = -1; idle_act = 0;
    hs_run = 0; vs_run = 0; hs_prev = 1'b0; vs_prev = 1'b0;
    rst_n_a = 1'b0; enable_a = 1'b0; pat_sel_a = 1'b0;
    fif_a.fifo_empty = 1'b0; fif_a.fifo_rdata = '0;
    rst_n_b = 1'b0; enable_b = 1'b0; pat_sel_b = 1'b1;
    fif_b.fifo_empty = 1'b1; fif_b.fifo_rdata = '0;
    clr_stats();

    // Reset state, both polarities.
    repeat (3) cycle();
    check_reset_a("rst_hold");
    check("b_rst/hsync", hs_b, 1);
    check("b_rst/vsync", vs_b, 1);
    check("b_rst/rgb_valid", de_b, 0);
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    repeat (2) cycle();
    check_reset_a("idle");

    // Start: counters at (0,4) in window 1, (0,0) in window 43.
    cyc = 0; clr_stats();
    enable_a = 1'b1;
    run_until(2);
    check("frame_start_hi", s_fs, 1);
    run_until(3);
    check("frame_start_1cyc", s_fs, 0);
    run_until(140);
    check("fs_first", fs_first, 2);
    check("fs_count", fs_cnt, 2);
    check("rd_first", rd_first, 43);
    check("de_first", de_first, 45);
    check("rd_per_frame", rd_cnt, 32);
    check("de_per_frame", de_cnt, 32);
    check("hsync_wmin", hs_wmin, 2);
    check("hsync_wmax", hs_wmax, 2);
    check("vsync_wmin", vs_wmin, 14);
    check("vsync_wmax", vs_wmax, 14);
    check("vsync_count", vs_rise, 2);
    check("no_underflow", s_uf, 0);
    for (int i = 0; i < 32; i++) check($sformatf("fifo_data[%0d]", i), de_q[i], i + 1);

    // Underflow: FIFO empty for pixels h=3..5 of line 0 (windows 144..146).
    clr_stats();
    run_until(143);
    fif_a.fifo_empty = 1'b1;
    run_until(144);
    check("uf_not_yet", s_uf, 0);
    run_until(145);
    check("uf_t1", s_uf, 1);
    check("uf_cnt_t1", s_ufc, 1);
    check("uf_no_pop", s_rd, 0);
    run_until(146);
    fif_a.fifo_empty = 1'b0;
    run_until(238);
    check("uf_rd_cnt", rd_cnt, 29);
    check("uf_de_cnt", de_cnt, 32);
    check("uf_sticky", s_uf, 1);
    check("uf_cnt", s_ufc, 3);
    check("uf_px2", de_q[2], 35);
    check("uf_px3", de_q[3], 0);
    check("uf_px5", de_q[5], 0);
    check("uf_px6", de_q[6], 36);
    check("uf_px31", de_q[31], 61);

    // Drop enable at v=2 of the frame starting in window 239.
    clr_stats();
    run_until(266);
    enable_a = 1'b0;
    idle_act = 0; idle_from = 339;
    run_until(400);
    check("stop_fs_count", fs_cnt, 1);
    check("stop_fs_last", fs_last, 296);
    check("stop_hs_rises", hs_rise, 7);
    check("stop_vs_rises", vs_rise, 1);
    check("stop_vs_width", vs_wmax, 14);
    check("stop_hs_width", hs_wmin, 2);
    check("stop_rd_cnt", rd_cnt, 32);
    check("stop_de_cnt", de_cnt, 32);
    check("idle_quiet", idle_act, 0);
    check("stop_uf_cnt", s_ufc, 3);
    idle_from = -1;

    // Restart, underflow 3 pixels, then 1-cycle reset mid-active-line.
    enable_a = 1'b1;
    run_until(443);
    fif_a.fifo_empty = 1'b1;
    run_until(446);
    fif_a.fifo_empty = 1'b0;
    rst_n_a = 1'b0; enable_a = 1'b0;
    run_until(447);
    check("pre_rst_uf_cnt", s_ufc, 6);
    check("pre_rst_de", s_de, 1);
    rst_n_a = 1'b1;
    run_until(448);
    check_reset_a("rst_mid");
    run_until(449);
    check_reset_a("rst_mid2");

    // Colour bars on DUT B (H_ACTIVE=16, active-low sync, FIFO empty).
    b_rd = 0; b_run = 0; b_wmin = 1000; b_wmax = 0;
    enable_b = 1'b1;
    for (int k = 0; k < 170; k++) begin
      @(negedge clk_1x);
      if (fif_b.fifo_rd_en) b_rd++;
      if (de_b) bq.push_back(rgb_b);
      if (!hs_b) b_run++;
      else if (b_run > 0) begin
        if (b_run < b_wmin) b_wmin = b_run;
        if (b_run > b_wmax) b_wmax = b_run;
        b_run = 0;
      end
      @(posedge clk_1x);
      #1;
    end
    check("bar_no_pop", b_rd, 0);
    check("bar_no_underflow", uf_b, 0);
    check("bar_de_cnt", bq.size(), 64);
    check("bar_hs_wmin", b_wmin, 2);
    check("bar_hs_wmax", b_wmax, 2);
    for (int i = 0; i < 64; i++)
      check($sformatf("bar[%0d]", i), bq[i], bars[(i % 16) / 2]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
